// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register: load/clear/hold in one edge, shifts/rotates one position per clock.
// An N-position shift completes N edges after acceptance; start is ignored while busy (no queuing).
module shift_reg_univ #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] amount,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nx;
   logic [2:0]       op_r;
   logic [2:0]       op_sel;
   logic [CNT_W-1:0] remaining;
   logic [CNT_W-1:0] amt_eff;
   logic             accept;
   logic             is_shift;
   logic [WIDTH-1:0] step_q;
   logic             step_sl;
   logic             step_sr;

   assign accept   = start && (state == IDLE);
   assign is_shift = (mode != M_HOLD) && (mode != M_LOAD) && (mode != M_CLR);
   assign amt_eff  = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

   // The acceptance edge uses the live mode; later steps use the captured one.
   assign op_sel = (state == SHIFT) ? op_r : mode;

   always_comb begin
      step_q  = q;
      step_sl = sout_l;
      step_sr = sout_r;
      case (op_sel)
         M_SHL: begin
            step_q  = {q[WIDTH-2:0], sin_r};
            step_sl = q[WIDTH-1];
         end
         M_SHR: begin
            step_q  = {sin_l, q[WIDTH-1:1]};
            step_sr = q[0];
         end
         M_ROL: begin
            step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
            step_sl = q[WIDTH-1];
         end
         M_ROR: begin
            step_q  = {q[0], q[WIDTH-1:1]};
            step_sr = q[0];
         end
         M_ASR: begin
            step_q  = {q[WIDTH-1], q[WIDTH-1:1]};
            step_sr = q[0];
         end
         default: begin
            step_q  = q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (accept && is_shift && (amt_eff > CNT_W'(1))) state_nx = SHIFT;
         SHIFT: if (remaining == CNT_W'(1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q         <= '0;
         sout_l    <= 1'b0;
         sout_r    <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
         op_r      <= M_HOLD;
      end else begin
         done <= 1'b0;
         if (state == SHIFT) begin
            q         <= step_q;
            sout_l    <= step_sl;
            sout_r    <= step_sr;
            remaining <= remaining - CNT_W'(1);
            done      <= (remaining == CNT_W'(1));
         end else if (accept) begin
            if (is_shift && (amt_eff != '0)) begin
               q         <= step_q;
               sout_l    <= step_sl;
               sout_r    <= step_sr;
               op_r      <= mode;
               remaining <= amt_eff - CNT_W'(1);
               done      <= (amt_eff == CNT_W'(1));
            end else begin
               if (mode == M_LOAD) q <= d;
               if (mode == M_CLR)  q <= '0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8) with a reference model checked every cycle.
module tb_shift_reg_univ;

   localparam int W = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    mode = 3'b000;
   logic [CW-1:0] amount = '0;
   logic [W-1:0]  d = '0;
   logic          sin_r = 1'b0;
   logic          sin_l = 1'b0;
   logic [W-1:0]  q;
   logic          sout_l, sout_r, busy, done;

   int nvec = 0;
   int nerr = 0;

   shift_reg_univ #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .amount(amount),
      .d(d), .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l),
      .sout_r(sout_r), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: register as an integer, pending steps as a plain count.
   int m_q = 0, m_sl = 0, m_sr = 0, m_left = 0, m_done = 0, m_op = 0;
   bit m_valid = 0;

   function automatic void m_step(int op);
      case (op)
         2: begin m_sl = (m_q >> 7) & 1; m_q = ((m_q * 2) + int'(sin_r)) % 256; end
         3: begin m_sr = m_q % 2; m_q = (m_q / 2) + (int'(sin_l) * 128); end
         4: begin m_sl = (m_q >> 7) & 1; m_q = ((m_q * 2) % 256) + m_sl; end
         5: begin m_sr = m_q % 2; m_q = (m_q / 2) + (m_sr * 128); end
         6: begin m_sr = m_q % 2; m_q = (m_q / 2) + (m_q & 128); end
         default: ;
      endcase
   endfunction

   always @(posedge clk) begin
      int n;
      if (reset) begin
         m_q = 0; m_sl = 0; m_sr = 0; m_left = 0; m_done = 0; m_valid = 1;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            m_step(m_op);
            m_left--;
            if (m_left == 0) m_done = 1;
         end else if (start) begin
            n = (int'(amount) > W) ? W : int'(amount);
            if (mode == 3'd1) m_q = int'(d);
            if (mode == 3'd7) m_q = 0;
            if (mode >= 3'd2 && mode <= 3'd6 && n > 0) begin
               m_op = int'(mode);
               m_step(m_op);
               m_left = n - 1;
            end
            if (m_left == 0) m_done = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         nvec++;
         if (int'(q) != m_q || int'(sout_l) != m_sl || int'(sout_r) != m_sr ||
             busy != (m_left > 0) || int'(done) != m_done) begin
            nerr++;
            $display("FAIL model t=%0t: got q=%h sl=%0d sr=%0d busy=%0d done=%0d, want q=%h sl=%0d sr=%0d busy=%0d done=%0d",
                     $time, q, sout_l, sout_r, busy, done, m_q[7:0], m_sl, m_sr, m_left > 0, m_done);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Drive a command for one cycle; returns just after the negedge following acceptance.
   task automatic cmd(input logic [2:0] m, input int amt, input logic [W-1:0] dv);
      @(negedge clk);
      start = 1'b1; mode = m; amount = CW'(amt); d = dv;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   // Wait for done, counting busy cycles; a timeout counts as a miscompare.
   task automatic wait_done(output int busy_cyc, output int done_cyc);
      int t;
      busy_cyc = 0; done_cyc = 0; t = 0;
      while (!done && t < 40) begin
         if (busy) busy_cyc++;
         @(negedge clk); #1; t++;
      end
      if (done) done_cyc++;
      if (t >= 40) begin
         nvec++; nerr++;
         $display("FAIL wait_done timeout: got no done, want done within 40 cycles");
      end
   endtask

   initial begin
      int bc, dc;
      start = 1'b1; mode = 3'd1; d = 8'hA5;
      repeat (2) @(negedge clk);
      reset = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_q", int'(q), 0);
      check("reset_busy_done", {busy, done}, 0);
      check("reset_sout", {sout_l, sout_r}, 0);

      cmd(3'd1, 0, 8'hA5);
      check("load_q", int'(q), 'hA5);
      check("load_done", int'(done), 1);
      @(negedge clk); #1;
      check("load_done_once", int'(done), 0);
      cmd(3'd7, 0, 8'h00);
      check("clear_q", int'(q), 0);
      check("clear_done", int'(done), 1);

      cmd(3'd1, 0, 8'hA5);
      sin_r = 1'b1;
      cmd(3'd2, 3, 8'h00);
      check("shl_s1", {int'(q), int'(sout_l), int'(busy)}, {32'h4B, 32'd1, 32'd1});
      @(negedge clk); #1;
      check("shl_s2", {int'(q), int'(sout_l), int'(busy)}, {32'h97, 32'd0, 32'd1});
      @(negedge clk); #1;
      check("shl_s3", {int'(q), int'(sout_l), int'(busy), int'(done)}, {32'h2F, 32'd1, 32'd0, 32'd1});
      sin_r = 1'b0;

      cmd(3'd1, 0, 8'h3C);
      cmd(3'd5, 8, 8'h00);
      wait_done(bc, dc);
      check("ror8_q", int'(q), 'h3C);
      check("ror8_busy", bc, 7);
      check("ror8_sout_r", int'(sout_r), 0);
      @(negedge clk); #1;
      check("ror8_done_once", int'(done), 0);

      cmd(3'd1, 0, 8'h80);
      cmd(3'd6, 12, 8'h00);
      wait_done(bc, dc);
      check("asr12_q", int'(q), 'hFF);
      check("asr12_busy", bc, 7);
      check("asr12_sout_r", int'(sout_r), 1);

      cmd(3'd1, 0, 8'hF0);
      sin_l = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = 3'd3; amount = CW'(5);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) begin start = 1'b1; mode = 3'd1; d = 8'h55; end
         else begin start = 1'b0; #1; break; end
      end
      check("shr5_q", int'(q), 'h07);
      check("shr5_done", int'(done), 1);
      check("shr5_sout_r", int'(sout_r), 1);

      cmd(3'd2, 0, 8'h00);
      check("amt0_q", int'(q), 'h07);
      check("amt0_done_busy", {done, busy}, 2'b10);

      cmd(3'd2, 6, 8'h00);
      reset = 1'b1;
      @(negedge clk); #1;
      check("abort_q", int'(q), 0);
      check("abort_busy_done", {busy, done}, 0);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk); #1;
         check("abort_no_done", int'(done), 0);
      end
      cmd(3'd1, 0, 8'h3C);
      check("post_reset_load", {int'(q), int'(done)}, {32'h3C, 32'd1});

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
